// File: rtl/ex_pattern_pkg.sv
// Shared types and constants for the memory pattern sequencer and its LFSRs.
package ex_pattern_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Feedback mask for x^8+x^4+x^3+x^2+1 in Galois form (x^8 term implied).
    localparam logic [7:0] LFSR_TAPS = 8'h1D;

    localparam int DEFAULT_SEED = 32;

endpackage

// File: rtl/ex_pattern_seq_if.sv
// Memory-controller handshake between the pattern sequencer (master) and memory (slave).
interface ex_pattern_seq_if;

    logic       ready;
    logic       wr_req;
    logic [7:0] wdata;
    logic       rd_req;
    logic       rdata_valid;
    logic [7:0] rdata;

    modport master (
        input  ready,
        input  rdata_valid,
        input  rdata,
        output wr_req,
        output wdata,
        output rd_req
    );

    modport slave (
        output ready,
        output rdata_valid,
        output rdata,
        input  wr_req,
        input  wdata,
        input  rd_req
    );

endinterface

// File: rtl/ex_pattern_lfsr.sv
// 8-bit Galois LFSR pattern generator with synchronous load and step hold.
module ex_pattern_lfsr
    import ex_pattern_pkg::*;
#(
    parameter logic [7:0] RESET_VALUE = 8'(DEFAULT_SEED)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       pause,
    input  logic       load,
    input  logic [7:0] ldata,
    output logic [7:0] data
);

    logic [7:0] step;

    // Shift left and fold the outgoing MSB back into the tapped bits.
    assign step = {data[6:0], 1'b0} ^ (data[7] ? LFSR_TAPS : 8'h00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= RESET_VALUE;
        end else if (load) begin
            data <= ldata;
        end else if (enable && !pause) begin
            data <= step;
        end
    end

endmodule

// File: rtl/ex_pattern_seq.sv
// Memory pattern test sequencer: writes BURSTS LFSR words, reads them back, checks them.
// Define EX_PATTERN_SEQ_ERRCNT_EN to build the saturating mismatch counter on err_count.
module ex_pattern_seq
    import ex_pattern_pkg::*;
#(
    parameter int SEED   = DEFAULT_SEED,
    parameter int BURSTS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    ex_pattern_seq_if.master mem,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count
);

    localparam int            CW        = $clog2(BURSTS + 1);
    localparam logic [CW-1:0] LAST      = CW'(BURSTS - 1);
    localparam logic [CW-1:0] FULL      = CW'(BURSTS);
    localparam logic [7:0]    SEED_BYTE = SEED[7:0];

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] ret_cnt;
    logic          fail;
    logic          fail_next;
    logic          wr_req_q;
    logic          rd_req_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic          launch;
    logic          wr_acc;
    logic          rd_acc;
    logic          take;
    logic          ret_last;
    logic          mismatch;
    logic [7:0]    wr_data;
    logic [7:0]    exp_data;

    // Returned words only count while a test is reading and until all BURSTS are in.
    assign launch    = start && (state == IDLE || state == DONE);
    assign wr_acc    = wr_req_q && mem.ready;
    assign rd_acc    = rd_req_q && mem.ready;
    assign take      = mem.rdata_valid && (state == READ || state == DRAIN) && (ret_cnt < FULL);
    assign ret_last  = (ret_cnt == FULL) || (take && ret_cnt == LAST);
    assign mismatch  = take && (mem.rdata != exp_data);
    assign fail_next = fail || mismatch;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: if (start) state_next = WRITE;
            WRITE:      if (wr_acc && wr_cnt == LAST) state_next = READ;
            READ:       if (rd_acc && rd_cnt == LAST) state_next = ret_last ? DONE : DRAIN;
            DRAIN:      if (ret_last) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            ret_cnt  <= '0;
            fail     <= 1'b0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state    <= state_next;
            wr_req_q <= (state_next == WRITE);
            rd_req_q <= (state_next == READ);
            busy_q   <= (state_next inside {WRITE, READ, DRAIN});
            done_q   <= (state_next == DONE);
            pass_q   <= (state_next == DONE) && !fail_next;
            if (launch) begin
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                ret_cnt <= '0;
                fail    <= 1'b0;
            end else begin
                if (wr_acc) wr_cnt <= wr_cnt + 1'b1;
                if (rd_acc) rd_cnt <= rd_cnt + 1'b1;
                if (take)   ret_cnt <= ret_cnt + 1'b1;
                fail <= fail_next;
            end
        end
    end

`ifdef EX_PATTERN_SEQ_ERRCNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= 8'h00;
        end else if (launch) begin
            err_cnt <= 8'h00;
        end else if (mismatch && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end

    assign err_count = err_cnt;
`else
    assign err_count = 8'h00;
`endif

    ex_pattern_lfsr #(.RESET_VALUE(SEED_BYTE)) u_wr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (wr_req_q),
        .pause   (!mem.ready),
        .load    (launch),
        .ldata   (SEED_BYTE),
        .data    (wr_data)
    );

    ex_pattern_lfsr #(.RESET_VALUE(SEED_BYTE)) u_exp_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (take),
        .pause   (1'b0),
        .load    (launch),
        .ldata   (SEED_BYTE),
        .data    (exp_data)
    );

    assign mem.wr_req = wr_req_q;
    assign mem.wdata  = wr_data;
    assign mem.rd_req = rd_req_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_ex_pattern_seq.sv
// Bench for ex_pattern_seq: loopback memory with stalls, latency and corruption vs a polynomial model.
module tb_ex_pattern_seq;

    localparam int SEED   = 32;
    localparam int BURSTS = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;

    int checks;
    int errors;

    ex_pattern_seq_if mem_bus ();

    ex_pattern_seq #(.SEED(SEED), .BURSTS(BURSTS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mem       (mem_bus),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Memory model state
    int         cyc;
    int         due_q[$];
    int         idx_q[$];
    int         last_due;
    int         rd_issued;
    logic [7:0] wr_log[$];
    logic [7:0] stall_log[$];
    bit         stall_arm;
    int         stall_cnt;
    bit         rand_ready;
    bit         rand_lat;
    bit         zero_reads;
    bit         corrupt_en[BURSTS];
    logic [7:0] corrupt_val[BURSTS];
    bit         inject_extra;
    bit         both_seen;

    // k-th pattern word: SEED multiplied by x^k in GF(2)[x] mod x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] model_word(input int k);
        logic [8:0] v;
        v = {1'b0, 8'(SEED)};
        for (int i = 0; i < k; i++) begin
            v = v << 1;
            if (v[8]) v = v ^ 9'h11D;
        end
        return v[7:0];
    endfunction

    function automatic int model_mismatches();
        int         n;
        logic [7:0] ret;
        n = 0;
        for (int k = 0; k < BURSTS; k++) begin
            if (zero_reads)          ret = 8'h00;
            else if (corrupt_en[k])  ret = corrupt_val[k];
            else                     ret = model_word(k);
            if (ret != model_word(k)) n++;
        end
        return n;
    endfunction

    function automatic logic [7:0] model_err_count(input int n);
`ifdef EX_PATTERN_SEQ_ERRCNT_EN
        return (n > 255) ? 8'hFF : 8'(n);
`else
        return (n < 0) ? 8'hFF : 8'h00;
`endif
    endfunction

    // Loopback memory: accepts on ready, returns reads in order after a latency.
    initial begin : memory_model
        int due;
        int idx;
        cyc = 0;
        mem_bus.ready       = 1'b0;
        mem_bus.rdata_valid = 1'b0;
        mem_bus.rdata       = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                due_q.delete();
                idx_q.delete();
                mem_bus.ready       = 1'b0;
                mem_bus.rdata_valid = 1'b0;
            end else begin
                if (stall_cnt > 0) begin
                    mem_bus.ready = 1'b0;
                    stall_cnt--;
                    if (mem_bus.wr_req) stall_log.push_back(mem_bus.wdata);
                end else if (rand_ready) begin
                    mem_bus.ready = ($urandom_range(0, 3) != 0);
                end else begin
                    mem_bus.ready = 1'b1;
                end
                if (mem_bus.wr_req && mem_bus.rd_req) both_seen = 1'b1;
                if (mem_bus.wr_req && mem_bus.ready) begin
                    wr_log.push_back(mem_bus.wdata);
                    if (stall_arm && wr_log.size() == 1) begin
                        stall_cnt = 3;
                        stall_arm = 1'b0;
                    end
                end
                if (mem_bus.rd_req && mem_bus.ready) begin
                    due = cyc + (rand_lat ? int'($urandom_range(1, 4)) : 2);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    due_q.push_back(due);
                    idx_q.push_back(rd_issued);
                    rd_issued++;
                end
                mem_bus.rdata_valid = 1'b0;
                if (inject_extra) begin
                    mem_bus.rdata_valid = 1'b1;
                    mem_bus.rdata       = 8'hFF;
                    inject_extra        = 1'b0;
                end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    void'(due_q.pop_front());
                    idx = idx_q.pop_front();
                    mem_bus.rdata_valid = 1'b1;
                    mem_bus.rdata       = (idx < wr_log.size()) ? wr_log[idx] : 8'h00;
                    if (zero_reads) mem_bus.rdata = 8'h00;
                    else if (idx < BURSTS && corrupt_en[idx]) mem_bus.rdata = corrupt_val[idx];
                end
            end
        end
    end

    task automatic clear_model();
        wr_log.delete();
        stall_log.delete();
        due_q.delete();
        idx_q.delete();
        last_due     = 0;
        rd_issued    = 0;
        stall_arm    = 1'b0;
        stall_cnt    = 0;
        rand_ready   = 1'b0;
        rand_lat     = 1'b0;
        zero_reads   = 1'b0;
        inject_extra = 1'b0;
        both_seen    = 1'b0;
        for (int k = 0; k < BURSTS; k++) begin
            corrupt_en[k]  = 1'b0;
            corrupt_val[k] = 8'h00;
        end
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mem_bus.wr_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_req got %b want 0", mem_bus.wr_req); end
        checks++; if (mem_bus.rd_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_req got %b want 0", mem_bus.rd_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if ({done, pass} !== 2'b00) begin errors++; $display("[TB] FAIL reset_done_pass got %b want 00", {done, pass}); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("[TB] FAIL reset_err_count got %0h want 0", err_count); end
        checks++; if (mem_bus.wdata !== model_word(0)) begin errors++; $display("[TB] FAIL reset_wdata got %0h want %0h", mem_bus.wdata, model_word(0)); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        clear_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (mem_bus.wr_req !== 1'b1) begin errors++; $display("[TB] FAIL basic_first_wr_latency got %b want 1", mem_bus.wr_req); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b want 1", busy); end
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_timeout got done=%b want 1", done); end
        checks++; if (wr_log.size() !== BURSTS) begin errors++; $display("[TB] FAIL basic_write_count got %0d want %0d", wr_log.size(), BURSTS); end
        for (int k = 0; k < BURSTS && k < wr_log.size(); k++) begin
            checks++; if (wr_log[k] !== model_word(k)) begin errors++; $display("[TB] FAIL basic_wdata[%0d] got %0h want %0h", k, wr_log[k], model_word(k)); end
        end
        checks++; if ({done, pass, busy} !== 3'b110) begin errors++; $display("[TB] FAIL basic_done_pass_busy got %b want 110", {done, pass, busy}); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("[TB] FAIL basic_err_count got %0h want 0", err_count); end
        checks++; if (both_seen !== 1'b0) begin errors++; $display("[TB] FAIL basic_wr_rd_overlap got %b want 0", both_seen); end
    endtask

    task automatic test_stall();
        bit ok;
        clear_model();
        stall_arm = 1'b1;
        launch();
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_timeout got done=%b want 1", done); end
        checks++; if (stall_log.size() !== 3) begin errors++; $display("[TB] FAIL stall_cycles got %0d want 3", stall_log.size()); end
        foreach (stall_log[i]) begin
            checks++; if (stall_log[i] !== model_word(1)) begin errors++; $display("[TB] FAIL stall_hold[%0d] got %0h want %0h", i, stall_log[i], model_word(1)); end
        end
        checks++; if (wr_log.size() !== BURSTS) begin errors++; $display("[TB] FAIL stall_write_count got %0d want %0d", wr_log.size(), BURSTS); end
        for (int k = 0; k < BURSTS && k < wr_log.size(); k++) begin
            checks++; if (wr_log[k] !== model_word(k)) begin errors++; $display("[TB] FAIL stall_wdata[%0d] got %0h want %0h", k, wr_log[k], model_word(k)); end
        end
        checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL stall_pass got %b want 1", pass); end
    endtask

    task automatic test_corrupt();
        bit ok;
        clear_model();
        corrupt_en[1]  = 1'b1;
        corrupt_val[1] = 8'h41;
        launch();
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL corrupt_timeout got done=%b want 1", done); end
        checks++; if (pass !== (model_mismatches() == 0)) begin errors++; $display("[TB] FAIL corrupt_pass got %b want %b", pass, model_mismatches() == 0); end
        checks++; if (err_count !== model_err_count(model_mismatches())) begin errors++; $display("[TB] FAIL corrupt_err_count got %0h want %0h", err_count, model_err_count(model_mismatches())); end
    endtask

    task automatic test_zero_reads();
        bit ok;
        clear_model();
        zero_reads = 1'b1;
        launch();
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL zero_timeout got done=%b want 1", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("[TB] FAIL zero_pass got %b want 0", pass); end
        checks++; if (err_count !== model_err_count(model_mismatches())) begin errors++; $display("[TB] FAIL zero_err_count got %0h want %0h", err_count, model_err_count(model_mismatches())); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        clear_model();
        launch();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (mem_bus.rd_req) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("[TB] FAIL midreset_reach_read got %b want 1", seen); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if ({mem_bus.wr_req, mem_bus.rd_req, busy} !== 3'b000) begin errors++; $display("[TB] FAIL midreset_async_outputs got %b want 000", {mem_bus.wr_req, mem_bus.rd_req, busy}); end
        checks++; if ({done, pass, err_count} !== 10'h000) begin errors++; $display("[TB] FAIL midreset_status got %0h want 0", {done, pass, err_count}); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({mem_bus.wr_req, mem_bus.rd_req, busy} !== 3'b000) begin errors++; $display("[TB] FAIL midreset_no_restart got %b want 000", {mem_bus.wr_req, mem_bus.rd_req, busy}); end
        clear_model();
        launch();
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL midreset_rerun_timeout got done=%b want 1", done); end
        checks++; if (pass !== 1'b1 || err_count !== 8'h00) begin errors++; $display("[TB] FAIL midreset_rerun got pass=%b err=%0h want pass=1 err=0", pass, err_count); end
        checks++; if (wr_log.size() !== BURSTS || wr_log[BURSTS-1] !== model_word(BURSTS - 1)) begin errors++; $display("[TB] FAIL midreset_rerun_writes got %0d words want %0d", wr_log.size(), BURSTS); end
    endtask

    task automatic test_ignore();
        bit         ok;
        logic [7:0] err_before;
        logic       pass_before;
        clear_model();
        corrupt_en[2]  = 1'b1;
        corrupt_val[2] = model_word(2) ^ 8'h01;
        launch();
        @(negedge clk);
        checks++; if (mem_bus.wr_req !== 1'b1) begin errors++; $display("[TB] FAIL ignore_in_write got %b want 1", mem_bus.wr_req); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ignore_timeout got done=%b want 1", done); end
        checks++; if (wr_log.size() !== BURSTS) begin errors++; $display("[TB] FAIL ignore_write_count got %0d want %0d", wr_log.size(), BURSTS); end
        for (int k = 0; k < BURSTS && k < wr_log.size(); k++) begin
            checks++; if (wr_log[k] !== model_word(k)) begin errors++; $display("[TB] FAIL ignore_wdata[%0d] got %0h want %0h", k, wr_log[k], model_word(k)); end
        end
        checks++; if (err_count !== model_err_count(model_mismatches())) begin errors++; $display("[TB] FAIL ignore_err_count got %0h want %0h", err_count, model_err_count(model_mismatches())); end
        err_before  = err_count;
        pass_before = pass;
        inject_extra = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (err_count !== err_before) begin errors++; $display("[TB] FAIL ignore_extra_err got %0h want %0h", err_count, err_before); end
        checks++; if ({done, pass} !== {1'b1, pass_before}) begin errors++; $display("[TB] FAIL ignore_extra_done_pass got %b want %b", {done, pass}, {1'b1, pass_before}); end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        for (int it = 0; it < 6; it++) begin
            clear_model();
            rand_ready = 1'b1;
            rand_lat   = 1'b1;
            for (int k = 0; k < BURSTS; k++) begin
                corrupt_en[k]  = ($urandom_range(0, 3) == 0);
                corrupt_val[k] = model_word(k) ^ 8'($urandom_range(1, 255));
            end
            n = model_mismatches();
            launch();
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL rand%0d_timeout got done=%b want 1", it, done); end
            checks++; if (wr_log.size() !== BURSTS) begin errors++; $display("[TB] FAIL rand%0d_write_count got %0d want %0d", it, wr_log.size(), BURSTS); end
            for (int k = 0; k < BURSTS && k < wr_log.size(); k++) begin
                checks++; if (wr_log[k] !== model_word(k)) begin errors++; $display("[TB] FAIL rand%0d_wdata[%0d] got %0h want %0h", it, k, wr_log[k], model_word(k)); end
            end
            checks++; if (pass !== (n == 0)) begin errors++; $display("[TB] FAIL rand%0d_pass got %b want %b", it, pass, n == 0); end
            checks++; if (err_count !== model_err_count(n)) begin errors++; $display("[TB] FAIL rand%0d_err_count got %0h want %0h", it, err_count, model_err_count(n)); end
            checks++; if (both_seen !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_wr_rd_overlap got %b want 0", it, both_seen); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_stall();
        test_corrupt();
        test_zero_reads();
        test_reset_mid();
        test_ignore();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_pattern_seq.md
EX_PATTERN_SEQ -- requirements
Module: ex_pattern_seq

Interface
REQ-001 The parameter list SHALL be:
- SEED, 32, 8-bit LFSR seed (bits [7:0] used).
- BURSTS, 16, write/read transfers per test; range 1..255.

REQ-002 The port list SHALL be:
- clk  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  one-cycle test launch pulse.
- ready  in  1  memory controller accepts the current wr_req/rd_req.
- wr_req  out  1  write request.
- wdata  out  8  write data, valid with wr_req.
- rd_req  out  1  read request.
- rdata_valid  in  1  read data return strobe.
- rdata  in  8  returned read data.
- busy  out  1  test in progress.
- done  out  1  test complete; held high.
- pass  out  1  done and no mismatch.
- err_count  out  8  saturating mismatch count.

Function
REQ-003 The FSM states SHALL be IDLE, WRITE, READ, DRAIN and DONE.

REQ-004 IDLE or DONE with start=1 SHALL go to WRITE next cycle:
- clear counters, fail flag, err_count, done and pass;
- write and expected generators reload SEED.

REQ-005 In WRITE, wr_req SHALL be 1 and wdata SHALL be the write generator value.
- The generator advances only on a cycle where wr_req && ready; it holds otherwise.

REQ-006 Generator step SHALL be the Galois LFSR with taps x^8+x^4+x^3+x^2+1.
- new[0]=old[7], new[1]=old[0], new[2]=old[1]^old[7], new[3]=old[2]^old[7], new[4]=old[3]^old[7], new[5]=old[4], new[6]=old[5], new[7]=old[6].

REQ-007 WRITE SHALL go to READ on the BURSTS-th accepted write; wr_req deasserts the next cycle.

REQ-008 In READ, rd_req SHALL be 1 until BURSTS requests are accepted (rd_req && ready), then the FSM goes to DRAIN.

REQ-009 Read data handling, valid in READ or DRAIN:
- each rdata_valid compares rdata with the expected generator value;
- the expected generator then advances;
- a returned-data counter increments.

REQ-010 A mismatch SHALL set the sticky fail flag and increment err_count, saturating at 255.

REQ-011 DRAIN SHALL go to DONE on the cycle the BURSTS-th rdata_valid is sampled.
- In DONE: done=1, pass=!fail, busy=0.

REQ-012 busy SHALL be 1 exactly in WRITE, READ and DRAIN.

REQ-013 Boundary rules:
- start while busy is ignored;
- rdata_valid in IDLE/DONE is ignored;
- rdata_valid beyond BURSTS returned words is ignored;
- wr_req and rd_req are never both 1;
- counters are $clog2(BURSTS+1) bits wide and never wrap.

REQ-014 Outputs SHALL be registered; latency from start to first wr_req is 1 cycle.

Reset
REQ-015 reset_n low SHALL asynchronously force:
- state IDLE;
- generators = SEED[7:0];
- counters, err_count and fail = 0;
- wr_req, rd_req, busy, done and pass = 0.

REQ-016 Reset asserted mid-test SHALL abort the test with no further requests; the next test requires a new start.

Configuration
REQ-017 With EX_PATTERN_SEQ_ERRCNT_EN defined, err_count SHALL behave per REQ-010.
- Without it, err_count is tied to 0, the counter is not built, and pass/fail are unchanged.

Structure
REQ-018 A shared package ex_pattern_pkg SHALL hold:
- the state enum;
- the LFSR tap constant;
- the default SEED.

REQ-019 Sub-module ex_pattern_lfsr:
- ports: clk, reset_n, enable, pause, load, ldata, data;
- SHALL implement REQ-006;
- SHALL be instantiated twice (write, expected).

Verification
REQ-020 The bench SHALL cover these scenarios:
- SEED=32, BURSTS=4, ready=1, loopback memory -> wdata 0x20,0x40,0x80,0x1D; done=1, pass=1, err_count=0.
- Same run, ready=0 for 3 cycles after the first write -> wdata holds 0x40 while stalled; sequence unchanged; pass=1.
- Memory corrupts the 2nd read to 0x41 -> pass=0, err_count=1, done=1.
- BURSTS=4, every read returns 0x00 -> err_count=4 (macro on) or 0 (macro off); pass=0.
- reset_n low mid-READ -> async IDLE, outputs 0; then start -> clean pass run.
- start pulsed during WRITE, extra rdata_valid in DONE -> no effect; err_count and pass unchanged.
